// File: rtl/hier_node_upstream_merger.sv
// rtl/hier_node_upstream_merger.sv - round-robin fan-in merger of child upstream beats
//
// Purpose: one node of the upstream fan-in tree. Picks one valid child per
// cycle (round-robin), tags the beat with the child index and holds it in a
// single output register toward the parent (1-cycle latency, full throughput).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   c_valid    in   [NUM_CHILD]         per-child beat valid
//   c_ready    out  [NUM_CHILD]         per-child accept, one-hot or zero
//   c_data     in   [NUM_CHILD*DATA_W]  child i payload at [i*DATA_W +: DATA_W]
//   p_valid    out  beat toward parent valid
//   p_ready    in   parent accepts beat
//   p_data     out  [DATA_W] merged payload
//   p_id       out  [ID_W]   index of the source child
//   grant_cnt  out  [16]     saturating accepted-beat counter, only when
//                            HIER_MERGE_STATS_EN is defined
//
// Optional feature macro: HIER_MERGE_STATS_EN

module hier_node_upstream_merger #(
    parameter int NUM_CHILD = 10,
    parameter int DATA_W    = 16,
    parameter int ID_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        c_valid,
    output logic [NUM_CHILD-1:0]        c_ready,
    input  logic [NUM_CHILD*DATA_W-1:0] c_data,
    output logic                        p_valid,
    input  logic                        p_ready,
    output logic [DATA_W-1:0]           p_data,
    output logic [ID_W-1:0]             p_id
`ifdef HIER_MERGE_STATS_EN
    ,
    output logic [15:0]                 grant_cnt
`endif
);

    generate
        if (NUM_CHILD < 1 || NUM_CHILD > 16) begin : g_bad_num_child
            $error("hier_node_upstream_merger: NUM_CHILD must be in 1..16");
        end
        if ((2 ** ID_W) < NUM_CHILD) begin : g_bad_id_w
            $error("hier_node_upstream_merger: ID_W too narrow for NUM_CHILD");
        end
    endgenerate

    logic              p_valid_q, p_valid_d;
    logic [DATA_W-1:0] p_data_q,  p_data_d;
    logic [ID_W-1:0]   p_id_q,    p_id_d;
    logic [ID_W-1:0]   rr_ptr_q,  rr_ptr_d;

    logic              load_ok;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   win_next;
    logic [DATA_W-1:0] win_data;
    logic              take;

    // Output register may accept a new beat when empty or draining this cycle.
    // Held low during reset so no child sees an accept while the node is idle.
    assign load_ok = rst_n && (!p_valid_q || p_ready);

    // Round-robin search: offsets 0..NUM_CHILD-1 from rr_ptr, wrapping at NUM_CHILD.
    always_comb begin
        int idx;
        int nxt;
        idx       = 0;
        nxt       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_next  = '0;
        win_data  = '0;
        c_ready   = '0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CHILD) begin
                idx = idx - NUM_CHILD;
            end
            if (!win_found && c_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
                nxt       = (idx == NUM_CHILD - 1) ? 0 : idx + 1;
                win_next  = ID_W'(nxt);
                win_data  = c_data[idx*DATA_W +: DATA_W];
                c_ready[idx] = load_ok;
            end
        end
    end

    assign take = load_ok && win_found;

    always_comb begin
        p_valid_d = p_valid_q;
        p_data_d  = p_data_q;
        p_id_d    = p_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (take) begin
            // New beat replaces (or retires-and-replaces) the held one: no bubble.
            p_valid_d = 1'b1;
            p_data_d  = win_data;
            p_id_d    = win_idx;
            rr_ptr_d  = win_next;
        end else if (p_ready) begin
            // Beat retired with nothing to follow; payload keeps last value.
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q <= 1'b0;
            p_data_q  <= '0;
            p_id_q    <= '0;
            rr_ptr_q  <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_data_q  <= p_data_d;
            p_id_q    <= p_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign p_valid = p_valid_q;
    assign p_data  = p_data_q;
    assign p_id    = p_id_q;

`ifdef HIER_MERGE_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    // Saturating count of accepted child beats.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (take && grant_cnt_q != 16'hFFFF) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_hier_node_upstream_merger.sv
// tb/tb_hier_node_upstream_merger.sv - self-checking bench for hier_node_upstream_merger
module tb_hier_node_upstream_merger;

    localparam int NC = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC-1:0]    c_valid;
    logic [NC-1:0]    c_ready;
    logic [NC*DW-1:0] c_data;
    logic             p_valid;
    logic             p_ready;
    logic [DW-1:0]    p_data;
    logic [IW-1:0]    p_id;
`ifdef HIER_MERGE_STATS_EN
    logic [15:0]      grant_cnt;
`endif

    hier_node_upstream_merger #(.NUM_CHILD(NC), .DATA_W(DW), .ID_W(IW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .c_data  (c_data),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .p_data  (p_data),
        .p_id    (p_id)
`ifdef HIER_MERGE_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] cv;
        logic          pr;
        logic [NC-1:0] rdy;
        logic          pv;
        logic [IW-1:0] id;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] child_data [NC];
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NC-1:0] cv, input logic pr, input logic [NC-1:0] rdy,
                                input logic pv, input int id);
        vec_t v;
        v.cv  = cv;
        v.pr  = pr;
        v.rdy = rdy;
        v.pv  = pv;
        v.id  = IW'(id);
        return v;
    endfunction

    // Drive at negedge, check combinational c_ready, then registered outputs after the edge.
    task automatic step(input vec_t v, input int n);
        @(negedge clk);
        c_valid = v.cv;
        p_ready = v.pr;
        #1;
        check($sformatf("c_ready[%0d]", n), 32'(c_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        check($sformatf("p_valid[%0d]", n), 32'(p_valid), 32'(v.pv));
        check($sformatf("p_id[%0d]", n), 32'(p_id), 32'(v.id));
        check($sformatf("p_data[%0d]", n), 32'(p_data), 32'(child_data[v.id]));
    endtask

    localparam logic [NC-1:0] ALL = '1;

    initial begin
        for (int i = 0; i < NC; i++) child_data[i] = DW'(16'h1000 + i);
        child_data[3] = 16'hA5A5;
        child_data[7] = 16'h1234;
        for (int i = 0; i < NC; i++) c_data[i*DW +: DW] = child_data[i];

        // Round-robin sweep 0..9,0 with all children valid
        for (int k = 0; k <= NC; k++) vecs.push_back(mk(ALL, 1'b1, NC'(1) << (k % NC), 1'b1, k % NC));
        vecs.push_back(mk('0, 1'b1, '0, 1'b0, 0));                 // drain, no c_valid
        vecs.push_back(mk(NC'(1) << 8, 1'b1, NC'(1) << 8, 1'b1, 8)); // last grant 8
        vecs.push_back(mk(NC'(1) << 7, 1'b1, NC'(1) << 7, 1'b1, 7)); // wrap search finds 7
        vecs.push_back(mk(NC'(1) << 3, 1'b1, NC'(1) << 3, 1'b1, 3)); // beat A5A5 id 3
        for (int k = 0; k < 5; k++) vecs.push_back(mk(ALL, 1'b0, '0, 1'b1, 3)); // backpressure
        vecs.push_back(mk(ALL, 1'b1, NC'(1) << 4, 1'b1, 4));       // release: child 4 same cycle
        vecs.push_back(mk('0, 1'b0, '0, 1'b1, 4));                 // hold, nothing new
        vecs.push_back(mk('0, 1'b1, '0, 1'b0, 4));                 // retire, payload kept
        vecs.push_back(mk('0, 1'b0, '0, 1'b0, 4));                 // idle
        vecs.push_back(mk(NC'(10'h220), 1'b0, NC'(1) << 5, 1'b1, 5)); // empty reg loads despite !p_ready
        vecs.push_back(mk(NC'(1) << 9, 1'b0, '0, 1'b1, 5));        // blocked by full reg

        // Reset with random c_valid
        rst_n   = 1'b0;
        p_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            c_valid = NC'($urandom);
            #1;
            check("rst c_ready", 32'(c_ready), 32'd0);
            check("rst p_valid", 32'(p_valid), 32'd0);
            check("rst p_id", 32'(p_id), 32'd0);
            check("rst p_data", 32'(p_data), 32'd0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        c_valid = '0;

        for (int n = 0; n < vecs.size(); n++) step(vecs[n], n);

        // Async reset while a beat is held
        @(negedge clk);
        check("pre-reset p_valid", 32'(p_valid), 32'd1);
        c_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst p_valid", 32'(p_valid), 32'd0);
        check("async rst c_ready", 32'(c_ready), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        p_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("post-rst idle p_valid", 32'(p_valid), 32'd0);
            check("post-rst idle p_id", 32'(p_id), 32'd0);
        end
        step(mk(NC'(1) << 2, 1'b1, NC'(1) << 2, 1'b1, 2), 100);

`ifdef HIER_MERGE_STATS_EN
        check("grant_cnt one", 32'(grant_cnt), 32'd1);
        @(negedge clk);
        c_valid = ALL;
        p_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        check("grant_cnt sat", 32'(grant_cnt), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
